// File: rtl/pipe_out_arbiter.sv
// Round-robin arbiter sharing one block-throttled pipe-out endpoint between N source FIFOs.
// Each granted block is one header word followed by BLOCK_WORDS-1 payload words from the winner.
module pipe_out_arbiter #(
  parameter int N           = 4,
  parameter int BLOCK_WORDS = 256,
  parameter int CW          = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pipe_out_read,
  output logic              pipe_out_ready,
  output logic [15:0]       pipe_out_data,
  input  logic [N*CW-1:0]   src_count,
  input  logic [N*16-1:0]   src_data,
  output logic [N-1:0]      src_rd,
  output logic [N-1:0]      grant,
  output logic [15:0]       blocks_sent,
  output logic              proto_err
);

  localparam int IW = $clog2(N);
  localparam int WW = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_RDY, S_XFER} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   src_idx_q, src_idx_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            ready_q, ready_d;
  logic [7:0]      seq_q, seq_d;
  logic [15:0]     blocks_q, blocks_d;
  logic [WW-1:0]   word_idx_q, word_idx_d;
  logic            proto_err_q, proto_err_d;
  logic            hdr_sel_q, hdr_sel_d;
  logic [15:0]     hdr_q, hdr_d;

  logic [N-1:0]    qual;
  logic [15:0]     src_word [N];
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  for (genvar gi = 0; gi < N; gi++) begin : g_src
    assign qual[gi]     = src_count[gi*CW +: CW] >= CW'(BLOCK_WORDS - 1);
    assign src_word[gi] = src_data[gi*16 +: 16];
  end

  // Walk downward so the nearest qualifier after rr_ptr is the last one assigned.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr_q) + k) % N);
      if (qual[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    src_idx_d   = src_idx_q;
    grant_d     = grant_q;
    ready_d     = ready_q;
    seq_d       = seq_q;
    blocks_d    = blocks_q;
    word_idx_d  = word_idx_q;
    proto_err_d = proto_err_q;
    hdr_sel_d   = hdr_sel_q;
    hdr_d       = hdr_q;
    src_rd      = '0;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (pipe_out_read) proto_err_d = 1'b1;
        if (enable) state_d = S_ARB;
      end
      S_ARB: begin
        // Clearing here also releases the grant held for the previous block's last word.
        grant_d = '0;
        if (pipe_out_read) proto_err_d = 1'b1;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (win_found) begin
          grant_d   = N'(1) << win_idx;
          rr_ptr_d  = win_idx;
          src_idx_d = win_idx;
          ready_d   = 1'b1;
          hdr_d     = {4'hA, 1'b0, 3'(win_idx), seq_q};
          state_d   = S_RDY;
        end
      end
      S_RDY: begin
        if (pipe_out_read) begin
          hdr_sel_d  = 1'b1;
          word_idx_d = WW'(1);
          state_d    = S_XFER;
        end
      end
      S_XFER: begin
        if (pipe_out_read) begin
          src_rd    = grant_q;
          hdr_sel_d = 1'b0;
          if (word_idx_q == WW'(BLOCK_WORDS - 1)) begin
            word_idx_d = '0;
            ready_d    = 1'b0;
            seq_d      = seq_q + 8'd1;
            blocks_d   = blocks_q + 16'd1;
            state_d    = enable ? S_ARB : S_IDLE;
          end else begin
            word_idx_d = word_idx_q + WW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IW'(N - 1);
      src_idx_q   <= '0;
      grant_q     <= '0;
      ready_q     <= 1'b0;
      seq_q       <= '0;
      blocks_q    <= '0;
      word_idx_q  <= '0;
      proto_err_q <= 1'b0;
      hdr_sel_q   <= 1'b0;
      hdr_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      src_idx_q   <= src_idx_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      seq_q       <= seq_d;
      blocks_q    <= blocks_d;
      word_idx_q  <= word_idx_d;
      proto_err_q <= proto_err_d;
      hdr_sel_q   <= hdr_sel_d;
      hdr_q       <= hdr_d;
    end
  end

  assign pipe_out_ready = ready_q;
  assign grant          = grant_q;
  assign blocks_sent    = blocks_q;
  assign proto_err      = proto_err_q;
  assign pipe_out_data  = hdr_sel_q ? hdr_q : ((|grant_q) ? src_word[src_idx_q] : 16'h0000);

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Directed bench for pipe_out_arbiter: models four capture FIFOs and plays the host reading blocks.
module tb_pipe_out_arbiter;

  localparam int N  = 4;
  localparam int BW = 256;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            pipe_out_read;
  logic            pipe_out_ready;
  logic [15:0]     pipe_out_data;
  logic [N*CW-1:0] src_count;
  logic [N*16-1:0] src_data;
  logic [N-1:0]    src_rd;
  logic [N-1:0]    grant;
  logic [15:0]     blocks_sent;
  logic            proto_err;

  logic [CW-1:0]   cnt [N];
  logic [15:0]     fifo_q [N];
  int              fifo_ptr [N];
  int              rd_cnt [N];
  logic            fifo_clr;
  int              exp_ptr [N];
  int              exp_blocks;
  int              n_checks = 0;
  int              n_pass = 0;

  always #5 clk = ~clk;

  pipe_out_arbiter #(.N(N), .BLOCK_WORDS(BW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pipe_out_read(pipe_out_read),
    .pipe_out_ready(pipe_out_ready), .pipe_out_data(pipe_out_data),
    .src_count(src_count), .src_data(src_data), .src_rd(src_rd), .grant(grant),
    .blocks_sent(blocks_sent), .proto_err(proto_err)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_count[i*CW +: CW] = cnt[i];
      src_data[i*16 +: 16]  = fifo_q[i];
    end
  end

  // FIFO model: each read returns {source, running index}, one cycle after the strobe.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_clr) begin
        fifo_ptr[i] <= 0;
        fifo_q[i]   <= 16'h0;
      end else if (src_rd[i]) begin
        fifo_q[i]   <= {4'(i), 12'(fifo_ptr[i])};
        fifo_ptr[i] <= fifo_ptr[i] + 1;
      end
      if (src_rd[i]) rd_cnt[i] <= rd_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; pipe_out_read = 1'b0; fifo_clr = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; fifo_clr = 1'b0;
    for (int i = 0; i < N; i++) exp_ptr[i] = 0;
    exp_blocks = 0;
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    cnt[0] = CW'(c0); cnt[1] = CW'(c1); cnt[2] = CW'(c2); cnt[3] = CW'(c3);
  endtask

  // Reads one block from src; drop_at clears enable before that read, stop_at abandons the block.
  task automatic run_block(input int src, input int seq, input int gapmax,
                           input int drop_at, input int stop_at);
    int to, errs, gap, others;
    int snap [N];
    logic [15:0] w, exp_w;
    to = 0;
    while (!pipe_out_ready && to < 50) begin @(negedge clk); to++; end
    check("ready_wait", 32'(to < 50), 32'd1);
    check("grant", 32'(grant), 32'(1 << src));
    for (int i = 0; i < N; i++) snap[i] = rd_cnt[i];
    errs = 0;
    w = 16'h0;
    for (int j = 0; j < BW; j++) begin
      if (j == stop_at) begin pipe_out_read = 1'b0; return; end
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      if (gap > 0) begin
        pipe_out_read = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          if (j > 0 && pipe_out_data !== w) errs++;
        end
      end
      if (j == drop_at) enable = 1'b0;
      if (pipe_out_ready !== 1'b1) errs++;
      pipe_out_read = 1'b1;
      @(negedge clk);
      w = pipe_out_data;
      if (j == 0) check("header", 32'(w), 32'({4'hA, 1'b0, 3'(src), 8'(seq)}));
      else begin
        exp_w = {4'(src), 12'(exp_ptr[src] + j - 1)};
        if (w !== exp_w) errs++;
      end
    end
    pipe_out_read = 1'b0;
    exp_ptr[src] += BW - 1;
    exp_blocks++;
    others = 0;
    for (int i = 0; i < N; i++) if (i != src) others += rd_cnt[i] - snap[i];
    check("payload", 32'(errs), 32'd0);
    check("ready_fall", 32'(pipe_out_ready), 32'd0);
    check("blocks_sent", 32'(blocks_sent), 32'(exp_blocks));
    check("grant_hold", 32'(grant), 32'(1 << src));
    check("rd_own", 32'(rd_cnt[src] - snap[src]), 32'(BW - 1));
    check("rd_other", 32'(others), 32'd0);
    $display("block src=%0d seq=%0d gapmax=%0d payload_errs=%0d blocks_sent=%0d",
             src, seq, gapmax, errs, blocks_sent);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) rd_cnt[i] = 0;
    set_counts(0, 0, 0, 0);
    do_reset();

    // Reset state
    check("rst_ready", 32'(pipe_out_ready), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_blocks", 32'(blocks_sent), 32'd0);
    check("rst_proto", 32'(proto_err), 32'd0);
    check("rst_data", 32'(pipe_out_data), 32'd0);
    check("rst_src_rd", 32'(src_rd), 32'd0);

    // Single source 2 at exactly one block
    set_counts(0, 0, 255, 0);
    enable = 1'b1;
    @(negedge clk);
    check("arb_ready_low", 32'(pipe_out_ready), 32'd0);
    @(negedge clk);
    check("arb_ready_high", 32'(pipe_out_ready), 32'd1);
    check("arb_grant", 32'(grant), 32'b0100);
    run_block(2, 0, 0, -1, -1);
    set_counts(0, 0, 0, 0);
    @(negedge clk);
    check("grant_clear", 32'(grant), 32'd0);

    // All sources full: round robin 0,1,2,3,0,1,2,3
    do_reset();
    set_counts(1023, 1023, 1023, 1023);
    enable = 1'b1;
    for (int b = 0; b < 8; b++) run_block(b % N, b, 0, -1, -1);

    // Source 1 one word short, then full
    do_reset();
    set_counts(0, 254, 0, 0);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("short_grant", 32'(grant), 32'd0);
    check("short_ready", 32'(pipe_out_ready), 32'd0);
    set_counts(0, 255, 0, 0);
    run_block(1, 0, 0, -1, -1);

    // Random gaps of 0..5 cycles between reads
    do_reset();
    set_counts(255, 0, 0, 0);
    enable = 1'b1;
    run_block(0, 0, 5, -1, -1);

    // enable dropped at word 100, then a stray read in IDLE
    do_reset();
    set_counts(0, 0, 0, 255);
    enable = 1'b1;
    run_block(3, 0, 0, 100, -1);
    repeat (3) @(negedge clk);
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_ready", 32'(pipe_out_ready), 32'd0);
    check("proto_before", 32'(proto_err), 32'd0);
    pipe_out_read = 1'b1;
    #1;
    check("stray_src_rd", 32'(src_rd), 32'd0);
    @(negedge clk);
    pipe_out_read = 1'b0;
    check("proto_err", 32'(proto_err), 32'd1);

    // Reset at word 50 of the second block
    do_reset();
    set_counts(0, 0, 0, 255);
    enable = 1'b1;
    run_block(3, 0, 0, -1, -1);
    run_block(3, 1, 0, -1, 50);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(pipe_out_ready), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_blocks", 32'(blocks_sent), 32'd0);
    do_reset();
    enable = 1'b1;
    run_block(3, 0, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_out_arbiter.md
# pipe_out_arbiter

Shares one block-throttled pipe-out endpoint (16-bit, ti_clk domain) between N source FIFOs. It grants the pipe to one source per block, round-robin, and only when that source holds a full block payload. It prefixes each block with a header word identifying the source and a sequence number. It sits between the per-channel capture FIFOs and the okBTPipeOut, driving that endpoint's ep_ready and ep_datain and consuming its ep_read.

## Interface
- N, 4: number of sources, 2..8.
- BLOCK_WORDS, 256: words per host block, power of two, ≥2. Word 0 is the header; BLOCK_WORDS-1 words are payload.
- CW, 10: width of each source fill count; must satisfy 2^CW > BLOCK_WORDS-1.

Ports:
- clk  in  1  ti_clk. All logic runs on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  from a wire-in; when low, no new block is granted.
- pipe_out_read  in  1  ep_read from the pipe-out endpoint.
- pipe_out_ready  out  1  ep_ready to the pipe-out endpoint.
- pipe_out_data  out  16  ep_datain to the pipe-out endpoint.
- src_count  in  N*CW  per-source FIFO fill level, source i at [i*CW +: CW].
- src_data  in  N*16  per-source FIFO dout, valid 1 cycle after src_rd.
- src_rd  out  N  per-source FIFO read strobe.
- grant  out  N  one-hot; the source owning the current block, 0 when none.
- blocks_sent  out  16  count of completed blocks; wraps.
- proto_err  out  1  sticky; set when pipe_out_read arrives outside a granted block.

## Operation
- States:
  - IDLE: enable=0.
  - ARB: search for a source.
  - RDY: grant held, ready high, no read yet.
  - XFER: reads in progress.
- Reset values: state=IDLE, pipe_out_ready=0, grant=0, src_rd=0, blocks_sent=0, seq=0, rr_ptr=N-1, word_idx=0, proto_err=0, pipe_out_data=0.
- IDLE→ARB when enable=1.
- ARB:
  - A source qualifies when src_count ≥ BLOCK_WORDS-1.
  - Search order is rr_ptr+1, rr_ptr+2, … mod N. The first qualifying source wins.
  - On a win: grant←one-hot(winner), rr_ptr←winner, pipe_out_ready←1, state→RDY.
  - With no qualifier, stay in ARB. If enable=0, go to IDLE.
- RDY: the first pipe_out_read moves the state to XFER and counts as word 0.
- word_idx counts reads 0..BLOCK_WORDS-1.
  - Read at word_idx=0: src_rd stays 0. Header {4'hA, 1'b0, src[2:0], seq[7:0]} is presented on pipe_out_data.
  - Reads at word_idx 1..BLOCK_WORDS-1: src_rd[grant] is asserted combinationally in the same cycle as pipe_out_read. All other src_rd stay 0.
- pipe_out_data mux select is registered from the read:
  - hdr_sel_q=1 after the header read: output the header register.
  - Otherwise: output src_data[granted source].
- Read at word_idx=BLOCK_WORDS-1 (last read), on that edge:
  - pipe_out_ready←0, seq←seq+1 (8-bit wrap), blocks_sent←blocks_sent+1.
  - grant is held one more cycle so the last data word is muxed, then grant←0.
  - State→ARB, or →IDLE if enable=0.
- enable falling mid-block: the current block completes in full, because the host is committed to it. No new grant follows.
- pipe_out_read in IDLE or ARB: ignored, proto_err←1, no src_rd issued.
- reset mid-block: returns to reset values immediately. Partial FIFO drain is accepted and the host transfer is aborted by software.
- The arbiter trusts src_count and never reads a FIFO it has not qualified.

## Timing
- Qualification to ready: src_count sampled in ARB on edge k → pipe_out_ready=1 from cycle k+1.
- Data latency: pipe_out_data is valid in the cycle after each pipe_out_read, matching the endpoint contract.
- Reads may be non-contiguous. Gaps of any length hold state, word_idx and data.
- pipe_out_ready falls the cycle after the last read is sampled.
- Minimum gap between blocks is 2 cycles: last read → ARB → RDY.
- Throughput: one word per cycle during XFER.
- Round-robin fairness: with all sources qualifying continuously, grants rotate 0,1,…,N-1,0.

## Test plan
- Reset, enable=1, src_count[2]=255, others 0 → grant=0b0100 and ready=1 one cycle after ARB. 256 reads → first word 0xA200, then 255 payload words from src 2, exactly 255 src_rd[2] pulses. blocks_sent=1, ready=0 after the last read.
- All four sources at count 1023, 8 back-to-back blocks → grant order 0,1,2,3,0,1,2,3; header seq 0..7; no src_rd on a non-granted source.
- Source 1 at count 254 then 255 → no grant while at 254. Grant begins only when count=255.
- Reads with random gaps of 0–5 cycles → data sequence identical to the gap-free run; ready stays high until the last read.
- enable cleared at word 100 of a block → block completes with 256 words, then IDLE with ready=0. A stray pipe_out_read in IDLE → proto_err=1, src_rd=0.
- reset asserted at word 50 → next cycle: ready=0, grant=0, blocks_sent=0. After re-enable the first header seq is 0x00.
